// File: rtl/match_resp_reorder.sv
// match_resp_reorder
//   Allocates a slot ID for each match request group, gathers tagged
//   per-lane match lengths from NUM_CH response channels, and hands
//   completed groups back to the job PE strictly in allocation order.
//   Up to GRP_DEPTH groups can be outstanding at once.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_group_valid/ready request-group handshake (ready = slot free)
//   req_group_strb        lanes that will receive a response
//   req_group_id          slot ID the next group will get (= wr_ptr)
//   resp_valid/ready      per-channel response handshake (ready tied high)
//   resp_tag              per channel {group_id, lane}
//   resp_match_len        per channel match length
//   resp_group_valid/ready head-group handshake towards the job PE
//   resp_group_match_len  head group lengths, lane i at [i*LEN_W +: LEN_W]
//   resp_group_strb       expected mask of the head group
//   resp_group_id         slot ID of the head group
//   occupancy             number of allocated slots
//   err_sticky            protocol violation seen since reset
module match_resp_reorder #(
  parameter int NUM_CH    = 4,
  parameter int LANES     = 4,
  parameter int LANE_LOG2 = 2,
  parameter int GRP_DEPTH = 4,
  parameter int GRP_LOG2  = 2,
  parameter int LEN_W     = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  req_group_valid,
  output logic                                  req_group_ready,
  input  logic [LANES-1:0]                      req_group_strb,
  output logic [GRP_LOG2-1:0]                   req_group_id,
  input  logic [NUM_CH-1:0]                     resp_valid,
  output logic [NUM_CH-1:0]                     resp_ready,
  input  logic [NUM_CH*(GRP_LOG2+LANE_LOG2)-1:0] resp_tag,
  input  logic [NUM_CH*LEN_W-1:0]               resp_match_len,
  output logic                                  resp_group_valid,
  input  logic                                  resp_group_ready,
  output logic [LANES*LEN_W-1:0]                resp_group_match_len,
  output logic [LANES-1:0]                      resp_group_strb,
  output logic [GRP_LOG2-1:0]                   resp_group_id,
  output logic [GRP_LOG2:0]                     occupancy,
  output logic                                  err_sticky
);

  localparam int TAG_W = GRP_LOG2 + LANE_LOG2;
  localparam logic [GRP_LOG2:0]   FULL_C  = (GRP_LOG2+1)'(GRP_DEPTH);
  localparam logic [GRP_LOG2:0]   CNT_ONE = (GRP_LOG2+1)'(1);
  localparam logic [GRP_LOG2-1:0] PTR_ONE = GRP_LOG2'(1);

  logic [GRP_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [GRP_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [GRP_LOG2:0]   cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [LANES-1:0]    expected_q [GRP_DEPTH];
  logic [LANES-1:0]    expected_d [GRP_DEPTH];
  logic [LANES-1:0]    received_q [GRP_DEPTH];
  logic [LANES-1:0]    received_d [GRP_DEPTH];
  logic [LEN_W-1:0]    len_q [GRP_DEPTH][LANES];
  logic [LEN_W-1:0]    len_d [GRP_DEPTH][LANES];

  logic                push_s;
  logic                pop_s;
  logic                head_done_s;
  logic [GRP_DEPTH-1:0] alloc_s;
  logic [LANES*LEN_W-1:0] match_len_s;

  assign req_group_ready  = (cnt_q != FULL_C);
  assign req_group_id     = wr_ptr_q;
  assign resp_ready       = '1;
  assign head_done_s      = (cnt_q != '0) && (received_q[rd_ptr_q] == expected_q[rd_ptr_q]);
  assign resp_group_valid = head_done_s;
  assign resp_group_strb  = expected_q[rd_ptr_q];
  assign resp_group_id    = rd_ptr_q;
  assign resp_group_match_len = match_len_s;
  assign occupancy        = cnt_q;
  assign err_sticky       = err_q;
  assign push_s           = req_group_valid && req_group_ready;
  assign pop_s            = head_done_s && resp_group_ready;

  // Slot g is live when its distance from rd_ptr (mod depth) is below cnt.
  always_comb begin
    logic [GRP_LOG2-1:0] dist_v;
    alloc_s = '0;
    dist_v  = '0;
    for (int g = 0; g < GRP_DEPTH; g++) begin
      dist_v     = GRP_LOG2'(g) - rd_ptr_q;
      alloc_s[g] = ({1'b0, dist_v} < cnt_q);
    end
  end

  // Head-group data; lanes outside the expected mask read as zero.
  always_comb begin
    match_len_s = '0;
    for (int i = 0; i < LANES; i++) begin
      if (expected_q[rd_ptr_q][i]) begin
        match_len_s[i*LEN_W +: LEN_W] = len_q[rd_ptr_q][i];
      end else begin
        match_len_s[i*LEN_W +: LEN_W] = '0;
      end
    end
  end

  // Next state: pop clears the head, responses fill lanes, push opens a slot.
  always_comb begin
    logic [GRP_LOG2-1:0]  g_v;
    logic [LANE_LOG2-1:0] l_v;
    logic [TAG_W-1:0]     tag_v;
    logic [LANES-1:0]     taken_v [GRP_DEPTH];
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    expected_d = expected_q;
    received_d = received_q;
    len_d      = len_q;
    g_v        = '0;
    l_v        = '0;
    tag_v      = '0;
    for (int g = 0; g < GRP_DEPTH; g++) begin
      taken_v[g] = '0;
    end

    if (pop_s) begin
      expected_d[rd_ptr_q] = '0;
      received_d[rd_ptr_q] = '0;
      rd_ptr_d             = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // Channels are scanned low to high so the lowest index wins a shared lane;
    // taken_v catches same-cycle duplicates that received_q cannot see yet.
    for (int c = 0; c < NUM_CH; c++) begin
      if (resp_valid[c]) begin
        tag_v = resp_tag[c*TAG_W +: TAG_W];
        g_v   = tag_v[TAG_W-1:LANE_LOG2];
        l_v   = tag_v[LANE_LOG2-1:0];
        if (alloc_s[g_v] && expected_q[g_v][l_v] && !received_q[g_v][l_v] && !taken_v[g_v][l_v]) begin
          taken_v[g_v][l_v]    = 1'b1;
          received_d[g_v][l_v] = 1'b1;
          len_d[g_v][l_v]      = resp_match_len[c*LEN_W +: LEN_W];
        end else begin
          err_d = 1'b1;
        end
      end else begin
        err_d = err_d;
      end
    end

    // The slot at wr_ptr is never live when a push fires, so no response
    // above can have touched it this cycle.
    if (push_s) begin
      expected_d[wr_ptr_q] = req_group_strb;
      received_d[wr_ptr_q] = '0;
      for (int i = 0; i < LANES; i++) begin
        len_d[wr_ptr_q][i] = '0;
      end
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; reset discards every slot and partial response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      for (int g = 0; g < GRP_DEPTH; g++) begin
        expected_q[g] <= '0;
        received_q[g] <= '0;
        for (int i = 0; i < LANES; i++) begin
          len_q[g][i] <= '0;
        end
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      expected_q <= expected_d;
      received_q <= received_d;
      len_q      <= len_d;
    end
  end

endmodule

// File: doc/match_resp_reorder.md
Name: match_resp_reorder

Overview:
- Parametrised, multi-group successor to the single-group match response synchroniser.
- Allocates a group ID for each match request group and collects tagged per-lane match lengths from NUM_CH channels (local and shared match PEs).
- Returns completed groups to the job PE strictly in allocation order.
- Up to GRP_DEPTH groups may be outstanding, so the scheduler can issue new groups while mesh responses for older ones are still in flight.

Parameters:
- NUM_CH, 4, number of response channels (local + shared match PEs).
- LANES, 4, lanes per group (lazy length).
- LANE_LOG2, 2, clog2(LANES).
- GRP_DEPTH, 4, outstanding group slots; power of two, at least 2.
- GRP_LOG2, 2, clog2(GRP_DEPTH).
- LEN_W, 8, match length width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_group_valid  in  1  new request group.
- req_group_ready  out  1  a slot is free.
- req_group_strb  in  LANES  lanes expecting a response.
- req_group_id  out  GRP_LOG2  slot ID for this group; scheduler places it in tag high bits.
- resp_valid  in  NUM_CH  per-channel response valid.
- resp_ready  out  NUM_CH  per-channel ready.
- resp_tag  in  NUM_CH*(GRP_LOG2+LANE_LOG2)  per channel {group_id, lane}.
- resp_match_len  in  NUM_CH*LEN_W  per-channel match length.
- resp_group_valid  out  1  head group complete.
- resp_group_ready  in  1  job PE accepts.
- resp_group_match_len  out  LANES*LEN_W  lane i at bits [i*LEN_W +: LEN_W].
- resp_group_strb  out  LANES  expected mask of the head group.
- resp_group_id  out  GRP_LOG2  ID of the head group.
- occupancy  out  GRP_LOG2+1  allocated slots.
- err_sticky  out  1  protocol error seen.

Behaviour:
- State:
  - Circular slot array indexed by wr_ptr/rd_ptr (GRP_LOG2 bits, natural wrap) and cnt (0..GRP_DEPTH).
  - Per slot: expected[LANES], received[LANES], len[LANES][LEN_W].
- Reset (async, rst_n low): ptrs=0, cnt=0, all expected/received/len=0, err_sticky=0. Consequently resp_group_valid=0, req_group_ready=1, req_group_id=0, occupancy=0, resp_ready all 1.
- Allocation:
  - req_group_ready = (cnt != GRP_DEPTH). It does not depend on the same-cycle pop.
  - req_group_id = wr_ptr, combinational.
  - On fire: slot[wr_ptr] gets expected=strb, received=0, len=0; wr_ptr+1.
  - strb=0 is allowed; that group is complete immediately.
- Responses:
  - resp_ready is tied to all 1s; slots are preallocated and no backpressure is applied.
  - A response on channel c, with tag g,l, is accepted into slot g when all of the following hold: slot g is allocated at the start of the cycle, expected[g][l]=1, and received[g][l]=0. On acceptance: len[g][l] <= match_len, received[g][l] <= 1.
  - Violations are dropped and set err_sticky. Violations are: an unallocated slot (including a slot allocated in the same cycle), an unexpected lane, and an already-received lane.
  - Multiple channels may write different lanes or slots in the same cycle.
  - Two channels targeting the same slot and lane in the same cycle: the lowest channel index wins; the others are dropped and set err_sticky.
- Output:
  - resp_group_valid = (cnt != 0) && (received[rd_ptr] == expected[rd_ptr]).
  - Data, strb and id are driven from slot[rd_ptr].
  - Lanes outside strb output 0.
  - Latency: the last response accepted in cycle T makes valid high in cycle T+1.
  - A later slot completing first is held until every older slot has been popped.
- Pop:
  - On valid && ready: expected[rd_ptr] and received[rd_ptr] are cleared, and rd_ptr+1.
  - Output is held stable while valid && !ready.
- Counter: simultaneous push and pop leave cnt unchanged. occupancy = cnt.
- err_sticky is cleared only by reset.
- Reset mid-operation discards all slots and partial responses.

Test Plan:
- Single group, in order:
  - Stimulus: alloc strb=4'b1111 (id 0); ch0..ch3 respond {0,0..3} with len 3,5,7,9 in one cycle.
  - Required: next cycle resp_group_valid=1, match_len lanes = 3,5,7,9, id=0; after pop, occupancy=0.
- Out-of-order completion:
  - Stimulus: alloc ids 0 and 1, strb=4'b0011 each; complete id 1 first (len 10,11), then id 0 (len 20,21) three cycles later.
  - Required: no valid until id 0 is complete; then id 0 (20,21) is output, then id 1 (10,11) on the following cycle with ready held at 1.
- Full/wrap:
  - Stimulus: allocate 4 groups with strb=0 while resp_group_ready=0.
  - Required: req_group_ready=0 and occupancy=4. Set ready=1: 4 pops, ids 0,1,2,3. A 5th allocation gets id 0 (wrap).
- Backpressure:
  - Stimulus: complete group while resp_group_ready=0 for 5 cycles.
  - Required: valid, data, id remain stable; pop happens exactly in the cycle ready=1.
- Errors:
  - Stimulus: ch0 and ch2 both send tag {0,1} in the same cycle with len 6 and 8.
  - Required: lane 1 = 6 and err_sticky=1.
  - Stimulus: a response to unallocated id 3.
  - Required: it is dropped with no state change other than err_sticky.
- Reset mid-flight:
  - Stimulus: 2 groups partially filled, rst_n pulsed low asynchronously.
  - Required: occupancy=0, valid=0, err_sticky=0, req_group_id=0 immediately.
